// File: rtl/i2s_pkg.sv
// Shared I2S transmitter types and constants.
// Samples are held left-justified in SAMPLE_DEPTH_MAX-bit fields so one
// struct serves every legal SAMPLE_DEPTH; the shift MSB is always bit 31.
package i2s_pkg;

  localparam int unsigned SAMPLE_DEPTH_DEFAULT = 16;
  localparam int unsigned SAMPLE_DEPTH_MAX     = 32;

  typedef struct packed {
    logic [SAMPLE_DEPTH_MAX-1:0] l;
    logic [SAMPLE_DEPTH_MAX-1:0] r;
  } pair_t;

  // Move a zero-extended sample up so its MSB lands on bit SAMPLE_DEPTH_MAX-1.
  function automatic logic [SAMPLE_DEPTH_MAX-1:0] left_justify(
    input logic [SAMPLE_DEPTH_MAX-1:0] sample,
    input int unsigned                 depth
  );
    return sample << (SAMPLE_DEPTH_MAX - depth);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Stereo sample handshake between a sample producer and i2s_tx.
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_DEPTH = SAMPLE_DEPTH_DEFAULT
);

  logic [SAMPLE_DEPTH-1:0] tx_data_l;
  logic [SAMPLE_DEPTH-1:0] tx_data_r;
  logic                    tx_data_valid;
  logic                    tx_data_ready;

  modport master (
    output tx_data_l,
    output tx_data_r,
    output tx_data_valid,
    input  tx_data_ready
  );

  modport slave (
    input  tx_data_l,
    input  tx_data_r,
    input  tx_data_valid,
    output tx_data_ready
  );

endinterface

// File: rtl/i2s_edge_sync.sv
// Two-flop synchroniser for an external clock-like signal, plus one-mclk
// rise/fall event detection on the synchronised level.
module i2s_edge_sync (
  input  logic mclk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_prev;

  // Synchronise the input and keep one cycle of history for edge detection.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_prev;
  assign o_fall  = ~r_sync[1] & r_prev;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter slave: bclk/wclk supplied externally, 2-entry stereo FIFO,
// MSB-first serialisation with one-bclk delay after each wclk edge.
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to enable the saturating
// underrun counter; otherwise underrun_count reads 0.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_DEPTH = SAMPLE_DEPTH_DEFAULT
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          bclk,
  input  logic          wclk,
  output logic          dout,
  i2s_tx_if.slave       tx,
  output logic          underrun,
  output logic [15:0]   underrun_count
);

  localparam int unsigned MsbIdx = SAMPLE_DEPTH_MAX - 1;

  logic  w_bclk_level, w_bclk_rise, w_bclk_fall;
  logic  w_wclk_level, w_wclk_rise, w_wclk_fall;
  logic  w_unused_edges;
  logic  w_slot_start, w_left_start, w_push, w_pop, w_empty_start;
  pair_t w_head, w_push_pair;

  logic                        r_w0, r_w1, r_chan, r_dout, r_underrun;
  logic [SAMPLE_DEPTH_MAX-1:0] r_sr_l, r_sr_r;
  pair_t                       r_fifo [2];
  logic                        r_wr_ptr, r_rd_ptr;
  logic [1:0]                  r_count;

  i2s_edge_sync u_bclk_sync (
    .mclk    (mclk),
    .reset   (reset),
    .i_async (bclk),
    .o_level (w_bclk_level),
    .o_rise  (w_bclk_rise),
    .o_fall  (w_bclk_fall)
  );

  i2s_edge_sync u_wclk_sync (
    .mclk    (mclk),
    .reset   (reset),
    .i_async (wclk),
    .o_level (w_wclk_level),
    .o_rise  (w_wclk_rise),
    .o_fall  (w_wclk_fall)
  );

  // Only bclk edges and the wclk level drive the datapath.
  assign w_unused_edges = ^{w_bclk_level, w_wclk_rise, w_wclk_fall};

  assign w_slot_start  = w_bclk_fall & (r_w0 ^ r_w1);
  assign w_left_start  = w_slot_start & ~r_w0;
  assign w_pop         = w_left_start & (r_count != 2'd0);
  assign w_empty_start = w_left_start & (r_count == 2'd0);

  assign tx.tx_data_ready = (r_count < 2'd2);
  assign w_push           = tx.tx_data_valid & tx.tx_data_ready;
  assign w_head           = r_fifo[r_rd_ptr];
  assign w_push_pair.l    = left_justify(SAMPLE_DEPTH_MAX'(tx.tx_data_l), SAMPLE_DEPTH);
  assign w_push_pair.r    = left_justify(SAMPLE_DEPTH_MAX'(tx.tx_data_r), SAMPLE_DEPTH);

  // wclk history sampled on each bclk rising event.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_w0 <= 1'b0;
      r_w1 <= 1'b0;
    end else if (w_bclk_rise) begin
      r_w1 <= r_w0;
      r_w0 <= w_wclk_level;
    end
  end

  // FIFO storage; contents are only meaningful where r_count says so.
  always_ff @(posedge mclk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_pair;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serialiser: load on left-slot start, shift out on each bclk falling event.
  // Zero fill on shift yields 0 for slot bits beyond the sample width.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_sr_l     <= '0;
      r_sr_r     <= '0;
      r_dout     <= 1'b0;
      r_chan     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_empty_start;
      if (w_slot_start) begin
        r_chan <= r_w0;
        if (!r_w0) begin
          if (w_pop) begin
            r_dout <= w_head.l[MsbIdx];
            r_sr_l <= w_head.l << 1;
            r_sr_r <= w_head.r;
          end else begin
            r_dout <= 1'b0;
            r_sr_l <= '0;
            r_sr_r <= '0;
          end
        end else begin
          r_dout <= r_sr_r[MsbIdx];
          r_sr_r <= r_sr_r << 1;
        end
      end else if (w_bclk_fall) begin
        if (r_chan) begin
          r_dout <= r_sr_r[MsbIdx];
          r_sr_r <= r_sr_r << 1;
        end else begin
          r_dout <= r_sr_l[MsbIdx];
          r_sr_l <= r_sr_l << 1;
        end
      end
    end
  end

  assign dout     = r_dout;
  assign underrun = r_underrun;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_count;

  // Saturating count of underrun pulses.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_underrun_count <= 16'd0;
    end else if (r_underrun && (r_underrun_count != 16'hFFFF)) begin
      r_underrun_count <= r_underrun_count + 16'd1;
    end
  end

  assign underrun_count = r_underrun_count;
`else
  assign underrun_count = 16'd0;
`endif

endmodule
